// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: op-length codes, FSM
// encoding and the alignment / strobe / load-extension helpers.
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Undefined op lengths report as misaligned so they never reach the bus.
  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] offset);
    case (op)
      OP_B, OP_BU: return 1'b1;
      OP_H, OP_HU: return ~offset[0];
      OP_W:        return offset == 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] op, input logic [1:0] offset);
    case (op)
      OP_B, OP_BU: return 4'b0001 << offset;
      OP_H, OP_HU: return 4'b0011 << offset;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] offset,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (op)
      OP_B:    return {{24{shifted[7]}}, shifted[7:0]};
      OP_BU:   return {24'h0, shifted[7:0]};
      OP_H:    return {{16{shifted[15]}}, shifted[15:0]};
      OP_HU:   return {16'h0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane steering: store data replication/strobes on the request
// side and byte/half extraction with extension on the response side.
module load_store_aligner
  import mem_pkg::*;
(
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_data,
  input  logic [2:0]  rsp_op,
  input  logic [1:0]  rsp_offset,
  input  logic [31:0] rsp_word,
  output logic        req_aligned,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic [31:0] rsp_load_data
);

  logic is_byte;
  logic is_half;

  assign is_byte = (req_op == OP_B) || (req_op == OP_BU);
  assign is_half = (req_op == OP_H) || (req_op == OP_HU);

  // Every lane carries a copy of the value so the strobes alone pick the target.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign req_wdata[8*gi +: 8] = is_byte ? req_data[7:0] :
                                  is_half ? req_data[8*(gi%2) +: 8] :
                                            req_data[8*gi +: 8];
  end

  assign req_aligned   = is_aligned(req_op, req_offset);
  assign req_wstrb     = store_strobe(req_op, req_offset);
  assign rsp_load_data = load_extend(rsp_op, rsp_offset, rsp_word);

endmodule

// File: rtl/mem_access_controller.sv
// Sequences one EX/MEM load or store onto the req/ack bus, stalling the
// pipeline until the access completes, is rejected, or times out.
module mem_access_controller
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_data,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [2:0]  mem_mem_op_length,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_load_data,
  output logic        mem_load_valid,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        mem_bus_error
);

  state_t      state_reg;
  logic [7:0]  timer_reg;
  logic [2:0]  op_reg;
  logic [1:0]  offset_reg;
  logic        is_load_reg;

  logic        access;
  logic        is_load;
  logic        aligned;
  logic [31:0] store_wdata;
  logic [3:0]  store_wstrb;
  logic [31:0] load_value;

  assign access  = mem_mem_read | mem_mem_write;
  assign is_load = mem_mem_read & ~mem_mem_write;

  load_store_aligner u_aligner (
    .req_op        (mem_mem_op_length),
    .req_offset    (mem_alu_result[1:0]),
    .req_data      (mem_rs2_data),
    .rsp_op        (op_reg),
    .rsp_offset    (offset_reg),
    .rsp_word      (bus_rdata),
    .req_aligned   (aligned),
    .req_wdata     (store_wdata),
    .req_wstrb     (store_wstrb),
    .rsp_load_data (load_value)
  );

  assign mem_stall = ((state_reg == ST_IDLE) && access) || (state_reg == ST_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      timer_reg      <= 8'd0;
      op_reg         <= 3'd0;
      offset_reg     <= 2'd0;
      is_load_reg    <= 1'b0;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= 32'h0;
      bus_wdata      <= 32'h0;
      bus_wstrb      <= 4'h0;
      mem_load_data  <= 32'h0;
      mem_load_valid <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_bus_error  <= 1'b0;
    end else begin
      mem_load_valid <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_bus_error  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (access) begin
            op_reg      <= mem_mem_op_length;
            offset_reg  <= mem_alu_result[1:0];
            is_load_reg <= is_load;
            timer_reg   <= 8'd0;
            if (aligned) begin
              state_reg <= ST_WAIT;
              bus_req   <= 1'b1;
              bus_we    <= mem_mem_write;
              bus_addr  <= {mem_alu_result[31:2], 2'b00};
              bus_wdata <= mem_mem_write ? store_wdata : 32'h0;
              bus_wstrb <= mem_mem_write ? store_wstrb : 4'h0;
            end else begin
              state_reg      <= ST_DONE;
              mem_misaligned <= 1'b1;
              if (is_load) mem_load_data <= 32'h0;
            end
          end
        end
        ST_WAIT: begin
          // A same-cycle ack takes priority over the timeout.
          if (bus_ack) begin
            state_reg <= ST_DONE;
            bus_req   <= 1'b0;
            if (is_load_reg) begin
              mem_load_valid <= 1'b1;
              mem_load_data  <= load_value;
            end
          end else if (timer_reg == 8'(TIMEOUT_CYCLES - 1)) begin
            state_reg     <= ST_DONE;
            bus_req       <= 1'b0;
            mem_bus_error <= 1'b1;
            mem_load_data <= 32'h0;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
